// File: rtl/xs_pkg.sv
// Shared XSwitch definitions: packet widths, field positions, opcodes,
// packet structs and the target FSM state encoding.
package xs_pkg;

   localparam int REQ_W = 66;
   localparam int RSP_W = 37;

   // Request packet field positions
   localparam int REQ_SRC_LSB   = 64;
   localparam int REQ_OP_LSB    = 62;
   localparam int REQ_ADDR_LSB  = 32;
   localparam int REQ_WDATA_LSB = 0;

   // Response packet field positions
   localparam int RSP_DST_LSB   = 35;
   localparam int RSP_OP_LSB    = 33;
   localparam int RSP_ERR_BIT   = 32;
   localparam int RSP_RDATA_LSB = 0;

   // Codes 2'b10 and 2'b11 are illegal and answered with err.
   typedef enum logic [1:0] {
      OP_RD = 2'b00,
      OP_WR = 2'b01
   } op_e;

   typedef struct packed {
      logic [1:0]  src_id;
      logic [1:0]  op;
      logic [29:0] addr;
      logic [31:0] wdata;
   } xs_req_t;

   typedef struct packed {
      logic [1:0]  dst_id;
      logic [1:0]  op;
      logic        err;
      logic [31:0] rdata;
   } xs_rsp_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

endpackage

// File: rtl/xs_mem_target_if.sv
// Request/response channel pair between the switch (master) and a target (slave).
//
// Handshake: a packet transfers on a rising clk edge where its vld and gnt are
// both high. The sender keeps vld and the packet stable until that edge; the
// receiver may drive gnt independently of vld.
interface xs_mem_target_if;
   import xs_pkg::*;

   logic             req_vld;
   logic [REQ_W-1:0] req_pkt;
   logic             req_gnt;
   logic             rsp_vld;
   logic [RSP_W-1:0] rsp_pkt;
   logic             rsp_gnt;

   modport master (
      output req_vld, req_pkt, rsp_gnt,
      input  req_gnt, rsp_vld, rsp_pkt
   );

   modport slave (
      input  req_vld, req_pkt, rsp_gnt,
      output req_gnt, rsp_vld, rsp_pkt
   );

endinterface

// File: rtl/xs_target_mem.sv
// Single-port DEPTHx32 word array with write enable and registered read.
// Kept separate so a technology SRAM macro can be dropped in.
module xs_target_mem #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   // Not reset; simulation starts from an all-zero array.
   logic [31:0] mem [DEPTH] = '{default: 32'h0};

   // One write or one registered read per enabled cycle.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/xs_mem_target.sv
// Memory-backed XSwitch target: accepts one request, waits WAIT_CYC cycles,
// performs the array access and holds the response until the switch takes it.
module xs_mem_target
   import xs_pkg::*;
#(
   parameter int          DEPTH     = 1024,
   parameter logic [29:0] BASE      = 30'h0,
   parameter int          WAIT_CYC  = 0,
   parameter bit          READ_ONLY = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   xs_mem_target_if.slave   bus,
   output state_e           dbg_state
);

   localparam int AW = $clog2(DEPTH);
   // 31-bit end bound so BASE+DEPTH near the top of the space cannot wrap.
   localparam logic [30:0] LIMIT = {1'b0, BASE} + 31'(DEPTH);

   state_e        state_q, state_d;
   logic [7:0]    cnt_q;
   xs_req_t       req_q;
   logic          err_q;
   logic          rd_ok_q;

   logic          in_range;
   logic          access_done;
   logic          mem_we;
   logic          mem_re;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_rdata;

   assign mem_addr    = AW'(req_q.addr - BASE);
   assign in_range    = (req_q.addr >= BASE) && ({1'b0, req_q.addr} < LIMIT);
   assign access_done = (state_q == ST_ACCESS) && (cnt_q == 8'd0);
   assign mem_we      = access_done && in_range && (req_q.op == OP_WR) && !READ_ONLY;
   assign mem_re      = access_done && in_range && (req_q.op == OP_RD);

   xs_target_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (mem_addr),
      .wdata (req_q.wdata),
      .rdata (mem_rdata)
   );

   // Header comes from the latched request; rdata is the memory's read
   // register, forced to zero unless the completed access was a good read.
   assign bus.rsp_pkt = {req_q.src_id, req_q.op, err_q, (rd_ok_q ? mem_rdata : 32'h0)};
   assign dbg_state   = state_q;

   // Next state and handshake outputs; gnt is gated by rst so it is low in reset.
   always_comb begin
      state_d     = state_q;
      bus.req_gnt = 1'b0;
      bus.rsp_vld = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bus.req_gnt = !rst;
            if (bus.req_vld) state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (cnt_q == 8'd0) state_d = ST_RESP;
         end
         ST_RESP: begin
            bus.rsp_vld = 1'b1;
            if (bus.rsp_gnt) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, request latch, wait counter and response status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         req_q   <= '0;
         err_q   <= 1'b0;
         rd_ok_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && bus.req_vld) begin
            req_q <= xs_req_t'(bus.req_pkt);
            cnt_q <= 8'(WAIT_CYC);
         end else if (state_q == ST_ACCESS && cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
         end
         if (access_done) begin
            err_q   <= !(mem_we || mem_re);
            rd_ok_q <= mem_re;
         end
      end
   end

endmodule

// File: tb/tb_xs_mem_target.sv
// Directed bench for xs_mem_target: three instances with different BASE,
// DEPTH, WAIT_CYC and READ_ONLY settings, a vector table of transactions and
// hand-written backpressure / mid-operation reset sequences.
module tb_xs_mem_target;
   import xs_pkg::*;

   localparam int N = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_vld [N];
   logic [65:0] req_pkt [N];
   logic        rsp_gnt [N];
   logic        req_gnt [N];
   logic        rsp_vld [N];
   logic [36:0] rsp_pkt [N];
   state_e      dbg_st  [N];

   int checks   = 0;
   int failures = 0;

   // Instance 0: BASE=0x100 DEPTH=16 WAIT=0 RW
   // Instance 1: BASE=0x0   DEPTH=8  WAIT=3 RW
   // Instance 2: BASE=0x20  DEPTH=8  WAIT=5 READ_ONLY
   for (genvar g = 0; g < N; g++) begin : u
      localparam int          DEP = (g == 0) ? 16 : 8;
      localparam logic [29:0] BAS = (g == 0) ? 30'h100 : (g == 1) ? 30'h0 : 30'h20;
      localparam int          WT  = (g == 0) ? 0 : (g == 1) ? 3 : 5;
      localparam bit          RO  = (g == 2);

      xs_mem_target_if bus ();
      assign bus.req_vld = req_vld[g];
      assign bus.req_pkt = req_pkt[g];
      assign bus.rsp_gnt = rsp_gnt[g];
      assign req_gnt[g]  = bus.req_gnt;
      assign rsp_vld[g]  = bus.rsp_vld;
      assign rsp_pkt[g]  = bus.rsp_pkt;

      xs_mem_target #(
         .DEPTH     (DEP),
         .BASE      (BAS),
         .WAIT_CYC  (WT),
         .READ_ONLY (RO)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .bus       (bus),
         .dbg_state (dbg_st[g])
      );
   end

   typedef struct {
      int          sel;
      logic [1:0]  src;
      logic [1:0]  op;
      logic [29:0] addr;
      logic [31:0] wdata;
      logic [36:0] exp;
   } vec_t;

   vec_t vq[$];

   function automatic int wait_of(input int s);
      return (s == 0) ? 0 : (s == 1) ? 3 : 5;
   endfunction

   function automatic logic [36:0] ex(input logic [1:0] d, input logic [1:0] op,
                                      input logic e, input logic [31:0] rd);
      return {d, op, e, rd};
   endfunction

   function automatic vec_t mk(input int s, input logic [1:0] src, input logic [1:0] op,
                               input logic [29:0] addr, input logic [31:0] wd,
                               input logic [36:0] exp);
      vec_t v;
      v.sel = s; v.src = src; v.op = op; v.addr = addr; v.wdata = wd; v.exp = exp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full transaction with rsp_gnt held high: accept, latency, gnt low while
   // busy, response contents, response transfer and return to IDLE.
   task automatic do_txn(input int s, input logic [65:0] pkt, input string name,
                         input logic [36:0] exp);
      int n;
      int lat;
      int gnt_bad;
      req_pkt[s] = pkt;
      req_vld[s] = 1'b1;
      rsp_gnt[s] = 1'b1;
      n = 0;
      while (!req_gnt[s] && n < 50) begin
         step();
         n++;
      end
      chk({name, " accept"}, req_gnt[s], 1);
      step();
      req_vld[s] = 1'b0;
      lat = 0;
      gnt_bad = 0;
      while (!rsp_vld[s] && lat < 300) begin
         if (req_gnt[s]) gnt_bad++;
         step();
         lat++;
      end
      chk({name, " latency"}, lat, 1 + wait_of(s));
      chk({name, " gnt_busy"}, gnt_bad, 0);
      chk({name, " rsp"}, rsp_pkt[s], exp);
      step();
      chk({name, " vld_drop"}, rsp_vld[s], 0);
      chk({name, " gnt_back"}, req_gnt[s], 1);
   endtask

   // Accept a request, advance k edges, then pulse rst asynchronously and
   // check the immediate effect and recovery.
   task automatic reset_mid(input int s, input logic [65:0] pkt, input int k,
                            input logic vld_before, input string name);
      req_pkt[s] = pkt;
      req_vld[s] = 1'b1;
      rsp_gnt[s] = 1'b0;
      chk({name, " accept"}, req_gnt[s], 1);
      step();
      req_vld[s] = 1'b0;
      for (int i = 0; i < k; i++) step();
      chk({name, " vld_before"}, rsp_vld[s], vld_before);
      #2 rst = 1'b1;
      #1;
      chk({name, " vld_async"}, rsp_vld[s], 0);
      chk({name, " pkt_reset"}, rsp_pkt[s], 0);
      chk({name, " state_idle"}, dbg_st[s], ST_IDLE);
      chk({name, " gnt_in_rst"}, req_gnt[s], 0);
      step();
      rst = 1'b0;
      rsp_gnt[s] = 1'b1;
      step();
      chk({name, " gnt_after"}, req_gnt[s], 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [36:0] bp_exp;
      logic [36:0] bp_first;
      int acc;
      int bad;
      int n;

      for (int i = 0; i < N; i++) begin
         req_vld[i] = 1'b0;
         req_pkt[i] = '0;
         rsp_gnt[i] = 1'b0;
      end

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("rst gnt%0d", i), req_gnt[i], 0);
         chk($sformatf("rst vld%0d", i), rsp_vld[i], 0);
         chk($sformatf("rst pkt%0d", i), rsp_pkt[i], 0);
         chk($sformatf("rst state%0d", i), dbg_st[i], ST_IDLE);
      end
      rst = 1'b0;
      step();
      for (int i = 0; i < N; i++) chk($sformatf("post_rst gnt%0d", i), req_gnt[i], 1);

      // Directed vector table (order matters: memory is stateful)
      vq.push_back(mk(0, 2'd2, 2'b01, 30'h105, 32'hDEADBEEF, ex(2'd2, 2'b01, 1'b0, 32'h0)));
      vq.push_back(mk(0, 2'd1, 2'b00, 30'h105, 32'h0,        ex(2'd1, 2'b00, 1'b0, 32'hDEADBEEF)));
      vq.push_back(mk(0, 2'd0, 2'b00, 30'h110, 32'h0,        ex(2'd0, 2'b00, 1'b1, 32'h0)));
      vq.push_back(mk(0, 2'd3, 2'b00, 30'h0FF, 32'h0,        ex(2'd3, 2'b00, 1'b1, 32'h0)));
      vq.push_back(mk(0, 2'd2, 2'b01, 30'h110, 32'h12345678, ex(2'd2, 2'b01, 1'b1, 32'h0)));
      vq.push_back(mk(0, 2'd1, 2'b11, 30'h100, 32'h55555555, ex(2'd1, 2'b11, 1'b1, 32'h0)));
      vq.push_back(mk(0, 2'd1, 2'b10, 30'h10F, 32'h66666666, ex(2'd1, 2'b10, 1'b1, 32'h0)));
      vq.push_back(mk(0, 2'd0, 2'b00, 30'h3FFFFFFF, 32'h0,   ex(2'd0, 2'b00, 1'b1, 32'h0)));
      vq.push_back(mk(0, 2'd0, 2'b00, 30'h100, 32'h0,        ex(2'd0, 2'b00, 1'b0, 32'h0)));
      vq.push_back(mk(0, 2'd3, 2'b00, 30'h10F, 32'h0,        ex(2'd3, 2'b00, 1'b0, 32'h0)));
      vq.push_back(mk(0, 2'd3, 2'b01, 30'h10F, 32'hA5A5A5A5, ex(2'd3, 2'b01, 1'b0, 32'h0)));
      vq.push_back(mk(0, 2'd2, 2'b00, 30'h10F, 32'h0,        ex(2'd2, 2'b00, 1'b0, 32'hA5A5A5A5)));
      vq.push_back(mk(0, 2'd2, 2'b00, 30'h100, 32'h0,        ex(2'd2, 2'b00, 1'b0, 32'h0)));
      vq.push_back(mk(1, 2'd1, 2'b01, 30'h007, 32'hCAFEF00D, ex(2'd1, 2'b01, 1'b0, 32'h0)));
      vq.push_back(mk(1, 2'd0, 2'b00, 30'h007, 32'h0,        ex(2'd0, 2'b00, 1'b0, 32'hCAFEF00D)));
      vq.push_back(mk(1, 2'd0, 2'b00, 30'h008, 32'h0,        ex(2'd0, 2'b00, 1'b1, 32'h0)));
      vq.push_back(mk(1, 2'd2, 2'b00, 30'h000, 32'h0,        ex(2'd2, 2'b00, 1'b0, 32'h0)));
      vq.push_back(mk(2, 2'd3, 2'b01, 30'h023, 32'h11112222, ex(2'd3, 2'b01, 1'b1, 32'h0)));
      vq.push_back(mk(2, 2'd1, 2'b00, 30'h023, 32'h0,        ex(2'd1, 2'b00, 1'b0, 32'h0)));
      vq.push_back(mk(2, 2'd1, 2'b00, 30'h027, 32'h0,        ex(2'd1, 2'b00, 1'b0, 32'h0)));
      vq.push_back(mk(2, 2'd2, 2'b00, 30'h028, 32'h0,        ex(2'd2, 2'b00, 1'b1, 32'h0)));
      vq.push_back(mk(2, 2'd2, 2'b00, 30'h01F, 32'h0,        ex(2'd2, 2'b00, 1'b1, 32'h0)));

      foreach (vq[i]) begin
         do_txn(vq[i].sel, {vq[i].src, vq[i].op, vq[i].addr, vq[i].wdata},
                $sformatf("vec%0d", i), vq[i].exp);
      end

      // Backpressure: rsp_gnt low for 10 cycles in RESP while req_vld stays high
      bp_exp = ex(2'd3, 2'b00, 1'b0, 32'hDEADBEEF);
      req_pkt[0] = {2'd3, 2'b00, 30'h105, 32'h0};
      req_vld[0] = 1'b1;
      rsp_gnt[0] = 1'b0;
      acc = 0;
      n = 0;
      while (!rsp_vld[0] && n < 50) begin
         if (req_vld[0] && req_gnt[0]) acc++;
         step();
         n++;
      end
      bp_first = rsp_pkt[0];
      chk("bp rsp", bp_first, bp_exp);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (req_vld[0] && req_gnt[0]) acc++;
         if (rsp_vld[0] !== 1'b1 || rsp_pkt[0] !== bp_first || req_gnt[0] !== 1'b0) bad++;
         step();
      end
      chk("bp stable", bad, 0);
      chk("bp accepts", acc, 1);
      req_vld[0] = 1'b0;
      rsp_gnt[0] = 1'b1;
      step();
      chk("bp vld_drop", rsp_vld[0], 0);
      chk("bp gnt_back", req_gnt[0], 1);

      // Reset during ACCESS with WAIT_CYC=5, then a normal read
      reset_mid(2, {2'd1, 2'b00, 30'h027, 32'h0}, 2, 1'b0, "rst_access");
      do_txn(2, {2'd2, 2'b00, 30'h020, 32'h0}, "rst_access rd", ex(2'd2, 2'b00, 1'b0, 32'h0));

      // Reset during a write's ACCESS: the write must not land
      reset_mid(1, {2'd1, 2'b01, 30'h003, 32'h77777777}, 1, 1'b0, "rst_wr");
      do_txn(1, {2'd0, 2'b00, 30'h003, 32'h0}, "rst_wr rd", ex(2'd0, 2'b00, 1'b0, 32'h0));

      // Reset while a response is pending: rsp_vld drops without a clock edge
      reset_mid(0, {2'd1, 2'b00, 30'h10F, 32'h0}, 1, 1'b1, "rst_resp");
      do_txn(0, {2'd1, 2'b00, 30'h10F, 32'h0}, "rst_resp rd", ex(2'd1, 2'b00, 1'b0, 32'hA5A5A5A5));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
